ram_banked_mp: RTL and testbench
================================

Name: ram_banked_mp

Overview:
- Multi-port, multi-bank single-port SRAM array for FFT data storage. Lets NUM_PORTS requesters (e.g. butterfly read/write lanes) access one address space in parallel.
- Address space is low-order interleaved across NUM_BANKS banks. A per-bank round-robin arbiter resolves conflicts with a valid/ready handshake.
- Reads return after a fixed, parametrised latency. Array contents are never cleared by writes-disabled cycles or by reset.

Parameters:
- DATA_WIDTH, 16, bits per word.
- MEM_SIZE, 1024, total words; power of two, multiple of NUM_BANKS.
- NUM_BANKS, 4, power of two, >=1; bank = addr[BANK_BITS-1:0].
- NUM_PORTS, 2, requesters, >=1.
- READ_LATENCY, 2, cycles from accepted read to rsp_valid, >=1.
- ADDR_WIDTH, $clog2(MEM_SIZE) (1 if MEM_SIZE==1), address bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port grant; transfer when valid&&ready.
- req_write  in  NUM_PORTS  1=write, 0=read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_PORTS  read data valid, one pulse per accepted read.
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  packed read data; holds last value when rsp_valid=0.

Behaviour:
- Reset (async assert, sync-safe release): req_ready=0 while rst_n=0, rsp_valid=0, rsp_rdata=0, all RR pointers=0, latency pipeline valids cleared. Array contents untouched (undefined at power-up).
- Mapping: bank = addr[BANK_BITS-1:0], row = addr[ADDR_WIDTH-1:BANK_BITS]. With NUM_BANKS=1, all rows are in bank 0.
- Arbitration (combinational, same cycle):
  - Each bank grants at most one requesting port; priority starts at that bank's rr_ptr and rotates upward.
  - req_ready[p] = 1 iff p is granted its target bank. It may depend on req_valid/req_addr of the same cycle; it never depends on rsp.
  - rr_ptr[b] updates to (granted port+1) mod NUM_PORTS only when bank b had more than one requester that cycle; otherwise it holds.
  - Ports hitting different banks are all granted in the same cycle.
- Write: on handshake, mem[bank][row] <= wdata at that clk edge. No response is generated.
- Read: on handshake, the bank read is registered at the next edge. Data is then delayed so rsp_valid[p]/rsp_rdata[p] assert exactly READ_LATENCY cycles after the handshake edge.
- Ordering: per-port responses are in request order, since latency is fixed.
- Back-to-back reads on a port are sustained at 1/cycle when uncontended.
- Read-during-write: cannot occur within a bank (one grant per bank). A read accepted the cycle after a write to the same address returns the new data.
- Starvation bound: a port continuously requesting a contended bank is granted within NUM_PORTS cycles.
- No backpressure on responses; the consumer must always accept rsp.
- Reset mid-operation: in-flight reads are dropped (rsp_valid never asserts for them). Writes completed before reset persist.
- Simultaneous write+read to the same address from different ports: same bank, so serialised by RR; the result depends on grant order, which is deterministic given rr_ptr.

Decomposition:
- Package ram_pkg: localparam functions for BANK_BITS/ROW_BITS computation and a port-index typedef helper. No hardware.
- Sub-module ram_bank:
  - Single-port, no reset on array, 1-cycle registered read; ports clk, en, we, row, wdata, rdata.
  - `ifdef FPGA ram_style="block" attribute on its array.
- Top: NUM_BANKS ram_bank instances, per-bank RR arbiter logic, per-port return mux (bank id tracked in pipeline), READ_LATENCY-1 stage output delay.

Test Plan (NUM_PORTS=2, NUM_BANKS=4, MEM_SIZE=64, DATA_WIDTH=16, READ_LATENCY=2):
- Reset, then port0 writes addr 5 = 0xA5A5 and addr 6 = 0x1234 on consecutive cycles; port0 reads 5,6 back-to-back -> rsp_valid0 at handshake+2 and +3, data 0xA5A5 then 0x1234; rsp_valid1 stays 0.
- Conflict: both ports read bank 1 (addr 1 and addr 9) for 4 cycles with rr_ptr=0 -> grants alternate p0,p1,p0,p1; each port gets exactly 2 responses in order.
- No conflict: p0 reads addr 2 (bank 2), p1 writes addr 3=0xBEEF (bank 3) in the same cycle -> both req_ready=1. A later p1 read of addr 3 returns 0xBEEF.
- Write-then-read: p1 writes addr 12=0x0F0F at cycle N; p0 reads addr 12 at N+1 -> rsp_rdata0=0x0F0F at N+3.
- Reset mid-flight: p0 read accepted at N, rst_n low at N+1 -> rsp_valid0 never pulses. After release, a read of previously written addr 5 still returns 0xA5A5.
- Disabled cycles: 20 idle cycles (req_valid=0) after writes -> subsequent reads return the original data (no clearing), and rsp_rdata holds its last value throughout the idle period.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - sizing helpers for the banked multi-port RAM
package ram_pkg;

    typedef int unsigned port_idx_t;

    function automatic int calc_addr_width(input int mem_size);
        return (mem_size > 1) ? $clog2(mem_size) : 1;
    endfunction

    function automatic int calc_bank_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

    function automatic int calc_row_bits(input int mem_size, input int num_banks);
        return calc_addr_width(mem_size) - calc_bank_bits(num_banks);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single-port bank with 1-cycle registered read
module ram_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ROW_W      = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_W-1:0]      row,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

`ifdef FPGA
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
`else
    logic [DATA_WIDTH-1:0] mem [DEPTH];
`endif

    // No reset on the array or read register: contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[row] <= wdata;
            end else begin
                rdata <= mem[row];
            end
        end
    end

endmodule

// File: rtl/ram_banked_mp.sv
// rtl/ram_banked_mp.sv - low-order interleaved multi-bank RAM with per-bank round-robin port arbitration
module ram_banked_mp
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_SIZE     = 1024,
    parameter int NUM_BANKS    = 4,
    parameter int NUM_PORTS    = 2,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_WIDTH   = calc_addr_width(MEM_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata
);

    localparam int BANK_BITS = calc_bank_bits(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int PORT_W    = idx_width(NUM_PORTS);
    localparam int DEPTH     = MEM_SIZE / NUM_BANKS;

    logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
    logic [BANK_W-1:0]     port_bank  [NUM_PORTS];
    logic [ROW_W-1:0]      port_row   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_addr[p]  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_wdata[p] = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        if (BANK_BITS == 0) begin : g_one_bank
            assign port_bank[p] = '0;
        end else begin : g_multi_bank
            assign port_bank[p] = port_addr[p][BANK_W-1:0];
        end
        if (ROW_BITS == 0) begin : g_no_row
            assign port_row[p] = '0;
        end else begin : g_row
            assign port_row[p] = port_addr[p][ADDR_WIDTH-1 -: ROW_W];
        end
    end

    logic [NUM_PORTS-1:0] bank_req [NUM_BANKS];
    logic [NUM_PORTS-1:0] bank_gnt [NUM_BANKS];
    logic [PORT_W-1:0]    gnt_idx  [NUM_BANKS];
    logic [PORT_W-1:0]    rr_ptr   [NUM_BANKS];
    logic [NUM_BANKS-1:0] gnt_any;
    logic [NUM_BANKS-1:0] contended;

    // Requests are masked during reset so req_ready stays low while rst_n=0.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req[b] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                bank_req[b][p] = rst_n && req_valid[p] && (int'(port_bank[p]) == b);
            end
        end
    end

    always_comb begin
        logic found;
        int   idx;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_gnt[b]  = '0;
            gnt_idx[b]   = '0;
            found        = 1'b0;
            idx          = 0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr[b]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!found && bank_req[b][idx]) begin
                    found         = 1'b1;
                    bank_gnt[b][idx] = 1'b1;
                    gnt_idx[b]    = PORT_W'(idx);
                end
            end
            gnt_any[b]   = found;
            contended[b] = ($countones(bank_req[b]) > 1);
        end
    end

    always_comb begin
        logic [NUM_PORTS-1:0] rdy;
        rdy = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rdy = rdy | bank_gnt[b];
        end
        req_ready = rdy;
    end

    // Pointer only moves on contention, so a lone requester never disturbs fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (contended[b]) begin
                    rr_ptr[b] <= (int'(gnt_idx[b]) == NUM_PORTS - 1) ? '0 : gnt_idx[b] + 1'b1;
                end
            end
        end
    end

    logic                  bank_we    [NUM_BANKS];
    logic [ROW_W-1:0]      bank_row   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b]    = req_write[gnt_idx[b]];
            bank_row[b]   = port_row[gnt_idx[b]];
            bank_wdata[b] = port_wdata[gnt_idx[b]];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ROW_W      (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (gnt_any[b]),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

    logic [NUM_PORTS-1:0]  rd_accept;
    logic [NUM_PORTS-1:0]  rd_v0;
    logic [BANK_W-1:0]     rd_bank0 [NUM_PORTS];
    logic [DATA_WIDTH-1:0] bank_rd  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rsp_word [NUM_PORTS];

    assign rd_accept = req_valid & req_ready & ~req_write;

    // Remember which bank each read went to so the return mux can pick its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v0 <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_bank0[p] <= '0;
            end
        end else begin
            rd_v0 <= rd_accept;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_accept[p]) begin
                    rd_bank0[p] <= port_bank[p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank_rd[p] = bank_rdata[rd_bank0[p]];
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        logic [DATA_WIDTH-1:0] hold [NUM_PORTS];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    hold[p] <= '0;
                end
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (rd_v0[p]) begin
                        hold[p] <= bank_rd[p];
                    end
                end
            end
        end

        assign rsp_valid = rd_v0;
        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rsp_word[p] = rd_v0[p] ? bank_rd[p] : hold[p];
            end
        end
    end else begin : g_latn
        logic [NUM_PORTS-1:0]  vs [1:READ_LATENCY-1];
        logic [DATA_WIDTH-1:0] ds [1:READ_LATENCY-1][NUM_PORTS];

        // Data stages load only with a valid so the last stage holds between responses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 1; s < READ_LATENCY; s++) begin
                    vs[s] <= '0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        ds[s][p] <= '0;
                    end
                end
            end else begin
                vs[1] <= rd_v0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (rd_v0[p]) begin
                        ds[1][p] <= bank_rd[p];
                    end
                end
                for (int s = 2; s < READ_LATENCY; s++) begin
                    vs[s] <= vs[s-1];
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (vs[s-1][p]) begin
                            ds[s][p] <= ds[s-1][p];
                        end
                    end
                end
            end
        end

        assign rsp_valid = vs[READ_LATENCY-1];
        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rsp_word[p] = ds[READ_LATENCY-1][p];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        assign rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = rsp_word[p];
    end

endmodule

// File: tb/tb_ram_banked_mp.sv
// tb/tb_ram_banked_mp.sv - directed self-checking bench for ram_banked_mp
module tb_ram_banked_mp;

    localparam int DW = 16;
    localparam int MS = 64;
    localparam int NB = 4;
    localparam int NP = 2;
    localparam int RL = 2;
    localparam int AW = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    rsp_valid;
    logic [NP*DW-1:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_banked_mp #(
        .DATA_WIDTH   (DW),
        .MEM_SIZE     (MS),
        .NUM_BANKS    (NB),
        .NUM_PORTS    (NP),
        .READ_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic w, input int a, input logic [DW-1:0] d);
        req_valid[p]             = v;
        req_write[p]             = w;
        req_addr[p*AW +: AW]     = AW'(a);
        req_wdata[p*DW +: DW]    = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rsp_rdata[p*DW +: DW];
    endfunction

    initial begin
        int  got0;
        int  got1;
        int  held_bad;
        int  stray;
        logic [NP-1:0] exp_v;

        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset: a valid request must not be granted while rst_n is low.
        drive(0, 1'b1, 1'b0, 5, 16'h0);
        #2;
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
        step();
        step();
        check("reset_ready_clk", 32'(req_ready), 32'h0);
        idle();
        rst_n = 1'b1;

        // Writes then back-to-back reads on port 0.
        step();
        drive(0, 1'b1, 1'b1, 5, 16'hA5A5); #1;
        check("wr5_ready", 32'(req_ready), 32'h1);
        step();
        drive(0, 1'b1, 1'b1, 6, 16'h1234); #1;
        check("wr6_ready", 32'(req_ready), 32'h1);
        step();
        drive(0, 1'b1, 1'b0, 5, 16'h0); #1;
        check("rd5_ready", 32'(req_ready), 32'h1);
        step();
        drive(0, 1'b1, 1'b0, 6, 16'h0); #1;
        check("rd6_ready", 32'(req_ready), 32'h1);
        check("rd5_not_early", 32'(rsp_valid), 32'h0);
        step();
        idle(); #1;
        check("rd5_valid", 32'(rsp_valid), 32'h1);
        check("rd5_data", 32'(rd(0)), 32'hA5A5);
        step();
        #1;
        check("rd6_valid", 32'(rsp_valid), 32'h1);
        check("rd6_data", 32'(rd(0)), 32'h1234);
        step();
        #1;
        check("rd6_done", 32'(rsp_valid), 32'h0);
        check("rd6_hold", 32'(rd(0)), 32'h1234);

        // Conflict on bank 1: seed addr 1 and 9, then both ports read for 4 cycles.
        drive(0, 1'b1, 1'b1, 1, 16'h1111); step();
        drive(0, 1'b1, 1'b1, 9, 16'h9999); step();
        idle();
        got0 = 0;
        got1 = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                drive(0, 1'b1, 1'b0, 1, 16'h0);
                drive(1, 1'b1, 1'b0, 9, 16'h0);
                #1;
                check($sformatf("conf_ready_c%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            end else begin
                idle();
                #1;
            end
            exp_v[0] = (i == 2 || i == 4);
            exp_v[1] = (i == 3 || i == 5);
            check($sformatf("conf_rsp_valid_c%0d", i), 32'(rsp_valid), 32'(exp_v));
            if (rsp_valid[0]) begin
                got0++;
                check($sformatf("conf_data0_c%0d", i), 32'(rd(0)), 32'h1111);
            end
            if (rsp_valid[1]) begin
                got1++;
                check($sformatf("conf_data1_c%0d", i), 32'(rd(1)), 32'h9999);
            end
            step();
        end
        check("conf_count0", 32'(got0), 32'd2);
        check("conf_count1", 32'(got1), 32'd2);

        // Different banks in one cycle: both granted.
        drive(0, 1'b1, 1'b1, 2, 16'h2222); step();
        idle();
        drive(0, 1'b1, 1'b0, 2, 16'h0);
        drive(1, 1'b1, 1'b1, 3, 16'hBEEF); #1;
        check("nocon_ready", 32'(req_ready), 32'h3);
        step();
        idle();
        drive(1, 1'b1, 1'b0, 3, 16'h0); #1;
        check("rd3_ready", 32'(req_ready), 32'h2);
        step();
        idle(); #1;
        check("rd2_valid", 32'(rsp_valid), 32'h1);
        check("rd2_data", 32'(rd(0)), 32'h2222);
        step();
        #1;
        check("rd3_valid", 32'(rsp_valid), 32'h2);
        check("rd3_data", 32'(rd(1)), 32'hBEEF);

        // Write on p1 then read on p0 the next cycle.
        step();
        drive(1, 1'b1, 1'b1, 12, 16'h0F0F); #1;
        check("wr12_ready", 32'(req_ready), 32'h2);
        step();
        idle();
        drive(0, 1'b1, 1'b0, 12, 16'h0); #1;
        check("rd12_ready", 32'(req_ready), 32'h1);
        step();
        idle();
        step();
        #1;
        check("rd12_valid", 32'(rsp_valid), 32'h1);
        check("rd12_data", 32'(rd(0)), 32'h0F0F);

        // Reset while a read is in flight: its response must never appear.
        step();
        drive(0, 1'b1, 1'b0, 5, 16'h0); #1;
        check("mid_rd_ready", 32'(req_ready), 32'h1);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_rdata", 32'(rsp_rdata), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[0]) stray++;
            step();
        end
        check("mid_rst_no_rsp", 32'(stray), 32'd0);
        drive(0, 1'b1, 1'b0, 5, 16'h0); #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        step();
        idle();
        step();
        #1;
        check("post_rst_valid", 32'(rsp_valid), 32'h1);
        check("post_rst_data", 32'(rd(0)), 32'hA5A5);

        // 20 idle cycles: output holds, no responses, contents kept.
        held_bad = 0;
        stray    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd(0) !== 16'hA5A5) held_bad++;
            if (rsp_valid !== 2'b00) stray++;
        end
        check("idle_hold", 32'(held_bad), 32'd0);
        check("idle_no_rsp", 32'(stray), 32'd0);
        drive(0, 1'b1, 1'b0, 6, 16'h0);
        drive(1, 1'b1, 1'b0, 3, 16'h0); #1;
        check("idle_rd_ready", 32'(req_ready), 32'h3);
        step();
        idle();
        step();
        #1;
        check("idle_rd_valid", 32'(rsp_valid), 32'h3);
        check("idle_rd6_data", 32'(rd(0)), 32'h1234);
        check("idle_rd3_data", 32'(rd(1)), 32'hBEEF);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
